// File: rtl/load_store_unit.sv
// Load/store unit: converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// whole-word accesses on a word-addressed data memory. Sub-word stores are
// done as read-modify-write; sub-word loads are extracted and extended.
// Misaligned or illegal requests are answered with an error and never
// reach the memory.
//
// Handshakes:
//   core side : a request is taken on the rising edge where
//               req_valid && req_ready; req_ready is high only in IDLE and
//               never during reset. The answer is a single-cycle
//               resp_valid pulse with no backpressure.
//   memory    : mem_out_valid / mem_in_valid are held from issue until the
//               matching *_ready pulse is seen and drop on that same edge,
//               so each request makes exactly one memory access. The two
//               valids are never high together.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_in_addr,
    output logic [31:0] mem_in_data,
    output logic        mem_in_valid,
    input  logic        mem_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_error;
    logic        req_is_sw;

    // Extract the addressed byte/halfword from a memory word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/halfword of the read word with store data.
    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane,
                                          input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (f3 == F3_B) begin
            case (lane)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (f3 == F3_H) begin
            if (lane[1]) r[31:16] = wd;
            else         r[15:0]  = wd;
        end
        return r;
    endfunction

    // Classify the incoming request; the result is acted on at the same
    // edge that latches it, so no extra decode cycle is needed.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_illegal = 1'b0;
            F3_BU, F3_HU:     req_illegal = req_write;
            default:          req_illegal = 1'b1;
        endcase
        case (req_funct3)
            F3_H, F3_HU: req_misaligned = req_addr[0];
            F3_W:        req_misaligned = (req_addr[1:0] != 2'b00);
            default:     req_misaligned = 1'b0;
        endcase
        req_error = req_illegal || req_misaligned;
        req_is_sw = req_write && (req_funct3 == F3_W);
    end

    assign req_ready = (state == IDLE) && !reset;
    assign dbg_state = state;

    // Main control FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            write_q       <= 1'b0;
            funct3_q      <= 3'd0;
            lane_q        <= 2'd0;
            wdata_q       <= 16'd0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_error    <= 1'b0;
            mem_in_addr   <= 32'd0;
            mem_in_data   <= 32'd0;
            mem_in_valid  <= 1'b0;
            mem_out_addr  <= 32'd0;
            mem_out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        funct3_q     <= req_funct3;
                        lane_q       <= req_addr[1:0];
                        wdata_q      <= req_wdata[15:0];
                        mem_in_addr  <= {req_addr[31:2], 2'b00};
                        mem_out_addr <= {req_addr[31:2], 2'b00};
                        resp_rdata   <= 32'd0;
                        resp_error   <= 1'b0;
                        if (req_error) begin
                            // Errors skip memory entirely.
                            resp_error <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_is_sw) begin
                            mem_in_data  <= req_wdata;
                            mem_in_valid <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            mem_out_valid <= 1'b1;
                            state         <= READ;
                        end
                    end
                end
                READ: begin
                    if (mem_out_ready) begin
                        mem_out_valid <= 1'b0;
                        if (write_q) begin
                            mem_in_data  <= merge(mem_out_data, funct3_q, lane_q, wdata_q);
                            mem_in_valid <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            resp_rdata <= extract(mem_out_data, funct3_q, lane_q);
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mem_in_ready) begin
                        mem_in_valid <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
